// File: rtl/lc3_memaccess_ctrl_if.sv
// Execute-stage request and data-memory bus of the LC3 memory-access controller.
// The master modport is the controller side; the slave modport is the environment.
interface lc3_memaccess_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] DMem_dout;
  logic              DMem_ack;
  logic              DMem_req;
  logic [ADDR_W-1:0] DMem_addr;
  logic [DATA_W-1:0] Dmem_din;
  logic              DMem_rd;
  logic [DATA_W-1:0] memout;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, op, addr_in, data_in, DMem_dout, DMem_ack,
    output DMem_req, DMem_addr, Dmem_din, DMem_rd, memout, busy, done, err
  );

  modport slave (
    output start, op, addr_in, data_in, DMem_dout, DMem_ack,
    input  DMem_req, DMem_addr, Dmem_din, DMem_rd, memout, busy, done, err
  );
endinterface

// File: rtl/lc3_memaccess_ctrl.sv
// LC3 memory-access stage: direct/indirect loads and stores over a req/ack data-memory
// bus with variable latency and a per-access wait timeout.
module lc3_memaccess_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                  clock,
  input logic                  reset,
  lc3_memaccess_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned LIMIT = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PTR,
    S_GAP,
    S_ACC,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [1:0]        op_q, op_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              req_q, req_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] din_q, din_n;
  logic              rd_q, rd_n;
  logic [DATA_W-1:0] memout_q, memout_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              timeout_c;

  // Last unacknowledged request cycle of the allowed window
  assign timeout_c = (MAX_WAIT != 0) && (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      data_q   <= '0;
      cnt      <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd_q     <= 1'b1;
      memout_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      data_q   <= data_n;
      cnt      <= cnt_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
      din_q    <= din_n;
      rd_q     <= rd_n;
      memout_q <= memout_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  // Bus outputs are computed for the state being entered, so they are registered with it
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    data_n   = data_q;
    cnt_n    = cnt;
    req_n    = 1'b0;
    addr_n   = addr_q;
    din_n    = din_q;
    rd_n     = rd_q;
    memout_n = memout_q;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;

    case (state)
      S_IDLE: begin
        rd_n = 1'b1;
        if (bus.start) begin
          op_n   = bus.op;
          data_n = bus.data_in;
          cnt_n  = '0;
          req_n  = 1'b1;
          addr_n = bus.addr_in;
          if (bus.op[0]) begin
            state_n = S_PTR;
          end else begin
            state_n = S_ACC;
            rd_n    = ~bus.op[1];
            if (bus.op[1]) din_n = bus.data_in;
          end
        end
      end

      S_PTR: begin
        if (bus.DMem_ack) begin
          state_n = S_GAP;
          addr_n  = bus.DMem_dout[ADDR_W-1:0];
        end else if (timeout_c) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          req_n = 1'b1;
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Pointer already sits in addr_q; set up the data access
      S_GAP: begin
        state_n = S_ACC;
        req_n   = 1'b1;
        cnt_n   = '0;
        rd_n    = ~op_q[1];
        if (op_q[1]) din_n = data_q;
      end

      S_ACC: begin
        if (bus.DMem_ack) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          if (!op_q[1]) memout_n = bus.DMem_dout;
        end else if (timeout_c) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          req_n = 1'b1;
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        rd_n    = 1'b1;
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  assign bus.DMem_req  = req_q;
  assign bus.DMem_addr = addr_q;
  assign bus.Dmem_din  = din_q;
  assign bus.DMem_rd   = rd_q;
  assign bus.memout    = memout_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lc3_memaccess_ctrl.sv
// Self-checking bench for lc3_memaccess_ctrl: directed vector table, reset abort,
// and randomized ops against a cycle-count reference model with a wait-state memory.
module tb_lc3_memaccess_ctrl;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int          MW     = 4;
  localparam int          MAXCYC = 60;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  lc3_memaccess_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lc3_memaccess_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] ptr;
    logic [15:0] rdata;
    int          pw;
    int          aw;
    int          exp_done;
    bit          exp_err;
    logic [15:0] exp_memout;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] model_mo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Completion cycle (counted from the start edge) and error flag from the op rules
  function automatic void model(input logic [1:0] o, input int pw, input int aw,
                                output int done_c, output bit e);
    int t;
    t = 0;
    e = 1'b0;
    if (o[0]) begin
      if (pw >= MW) begin
        done_c = MW + 1;
        e      = 1'b1;
        return;
      end
      t = pw + 2;
    end
    if (aw >= MW) begin
      done_c = t + MW + 1;
      e      = 1'b1;
    end else begin
      done_c = t + aw + 2;
    end
  endfunction

  // One operation: start in the current IDLE cycle, act as memory, check bus each cycle
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] p, input logic [15:0] r, input int pw, input int aw,
                        input int exp_done, input bit exp_err, input logic [15:0] exp_mo,
                        input string tag);
    int    p_len, d_start, d_len, cyc, bad;
    bit    in_ptr, in_dat;
    string first;
    @(negedge clock);
    chk({tag, ".idle"}, 32'({bus.busy, bus.DMem_rd, bus.DMem_req, bus.done}), 32'(4'b0100));
    bus.start     = 1'b1;
    bus.op        = o;
    bus.addr_in   = a;
    bus.data_in   = d;
    bus.DMem_ack  = 1'($urandom);
    bus.DMem_dout = 16'($urandom);
    p_len   = 0;
    d_start = 1;
    d_len   = 0;
    if (o[0]) begin
      p_len   = (pw + 1 < MW) ? pw + 1 : MW;
      d_start = p_len + 2;
    end
    if (!o[0] || pw < MW) d_len = (aw + 1 < MW) ? aw + 1 : MW;
    first = "";
    bad   = 0;
    @(negedge clock);
    cyc = 1;
    // Stray start with junk fields while busy
    bus.start   = 1'b1;
    bus.op      = 2'($urandom);
    bus.addr_in = 16'($urandom);
    bus.data_in = 16'($urandom);
    while (cyc < MAXCYC && !bus.done) begin
      if (cyc >= 2) bus.start = 1'b0;
      in_ptr = (cyc <= p_len);
      in_dat = (d_len > 0) && (cyc >= d_start) && (cyc < d_start + d_len);
      if ((bus.DMem_req !== (in_ptr || in_dat)) || (bus.busy !== 1'b1) ||
          (in_ptr && (bus.DMem_addr !== a || bus.DMem_rd !== 1'b1)) ||
          (in_dat && (bus.DMem_addr !== (o[0] ? p : a) || bus.DMem_rd !== ~o[1] ||
                      (o[1] && bus.Dmem_din !== d)))) begin
        if (bad == 0)
          first = $sformatf("cyc%0d req=%b addr=%h rd=%b din=%h want req=%b", cyc,
                            bus.DMem_req, bus.DMem_addr, bus.DMem_rd, bus.Dmem_din,
                            in_ptr || in_dat);
        bad++;
      end
      if (in_ptr) begin
        bus.DMem_ack  = (cyc == pw + 1);
        bus.DMem_dout = bus.DMem_ack ? p : 16'($urandom);
      end else if (in_dat) begin
        bus.DMem_ack  = (cyc == d_start + aw);
        bus.DMem_dout = bus.DMem_ack ? r : 16'($urandom);
      end else begin
        bus.DMem_ack  = 1'($urandom);
        bus.DMem_dout = 16'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    bus.start    = 1'b0;
    bus.DMem_ack = 1'b0;
    chk({tag, ".done_seen"}, 32'(bus.done), 32'(1));
    chk({tag, ".done_cycle"}, 32'(cyc), 32'(exp_done));
    chk({tag, ".err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, ".memout"}, 32'(bus.memout), 32'(exp_mo));
    chk({tag, ".bus ", first}, 32'(bad), 32'(0));
  endtask

  initial begin
    logic [1:0]  o;
    logic [15:0] a, d, p, r;
    int          pw, aw, ed;
    bit          ee;

    vecs[0] = '{2'b00, 16'h3000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 2, 1'b0, 16'hBEEF};
    vecs[1] = '{2'b11, 16'h4000, 16'h1234, 16'h5000, 16'h0000, 2, 0, 6, 1'b0, 16'hBEEF};
    vecs[2] = '{2'b00, 16'h3100, 16'h0000, 16'h0000, 16'h1111, 0, 4, 5, 1'b1, 16'hBEEF};
    vecs[3] = '{2'b00, 16'h3100, 16'h0000, 16'h0000, 16'h2222, 0, 3, 5, 1'b0, 16'h2222};
    vecs[4] = '{2'b01, 16'h6000, 16'h0000, 16'h7000, 16'h3333, 0, 1, 5, 1'b0, 16'h3333};
    vecs[5] = '{2'b10, 16'h8000, 16'hABCD, 16'h0000, 16'h0000, 0, 1, 3, 1'b0, 16'h3333};
    vecs[6] = '{2'b01, 16'h9000, 16'h0000, 16'hA000, 16'h4444, 4, 0, 5, 1'b1, 16'h3333};
    vecs[7] = '{2'b11, 16'hB000, 16'h5555, 16'hC000, 16'h0000, 1, 9, 8, 1'b1, 16'h3333};

    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.addr_in   = '0;
    bus.data_in   = '0;
    bus.DMem_ack  = 1'b0;
    bus.DMem_dout = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset.ctrl", 32'({bus.DMem_req, bus.DMem_rd, bus.busy, bus.done, bus.err}), 32'(5'b01000));
    chk("reset.addr", 32'(bus.DMem_addr), 32'(0));
    chk("reset.memout", 32'(bus.memout), 32'(0));
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].ptr, vecs[i].rdata,
             vecs[i].pw, vecs[i].aw, vecs[i].exp_done, vecs[i].exp_err,
             vecs[i].exp_memout, $sformatf("vec%0d", i));
    end

    // Reset while the pointer read is stalled: everything returns to reset values at once
    @(negedge clock);
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.addr_in = 16'h4444;
    bus.DMem_ack = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    chk("rstptr.req", 32'(bus.DMem_req), 32'(1));
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rstptr.ctrl", 32'({bus.DMem_req, bus.DMem_rd, bus.busy, bus.done, bus.err}), 32'(5'b01000));
    chk("rstptr.addr", 32'(bus.DMem_addr), 32'(0));
    chk("rstptr.din", 32'(bus.Dmem_din), 32'(0));
    chk("rstptr.memout", 32'(bus.memout), 32'(0));
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.DMem_ack = 1'($urandom);
      @(negedge clock);
      chk($sformatf("rstptr.quiet%0d", k), 32'({bus.done, bus.busy, bus.DMem_req}), 32'(0));
    end
    bus.DMem_ack = 1'b0;
    model_mo = 16'h0000;

    for (int i = 0; i < 40; i++) begin
      o  = 2'($urandom);
      a  = 16'($urandom);
      d  = 16'($urandom);
      p  = 16'($urandom);
      r  = 16'($urandom);
      pw = $urandom_range(0, 5);
      aw = $urandom_range(0, 5);
      model(o, pw, aw, ed, ee);
      if (!ee && !o[1]) model_mo = r;
      run_op(o, a, d, p, r, pw, aw, ed, ee, model_mo, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_memaccess_ctrl.md
Name: lc3_memaccess_ctrl

Overview:
Parametrised LC3 memory-access stage controller. Executes direct or indirect loads and stores (LD/LDR/LDI, ST/STR/STI) against a variable-latency data memory using a req/ack handshake. Sits between the execute stage and data memory, and drives the DMem_addr/Dmem_din/DMem_rd/memout bus signals. Successor to the fixed-latency 16-bit memaccess stage: widths are configurable, the memory may stall, and a per-access timeout is detected.

Parameters:
ADDR_W, 16, data-memory address width
DATA_W, 16, data word width; must be >= ADDR_W (indirect pointer = DMem_dout[ADDR_W-1:0])
MAX_WAIT, 8, max cycles DMem_req may wait for DMem_ack before abort; 0 disables the timeout

Ports:
clock      input   1        rising-edge clock
reset      input   1        asynchronous, active-low reset
start      input   1        request strobe; sampled only in IDLE
op         input   2        00 load direct, 01 load indirect, 10 store direct, 11 store indirect
addr_in    input   ADDR_W   effective address (pointer address for indirect ops)
data_in    input   DATA_W   store data
DMem_dout  input   DATA_W   memory read data, valid when DMem_ack=1
DMem_ack   input   1        memory completes the current access
DMem_req   output  1        access request
DMem_addr  output  ADDR_W   access address
Dmem_din   output  DATA_W   write data
DMem_rd    output  1        1 = read, 0 = write
memout     output  DATA_W   last loaded data
busy       output  1        op in progress (state != IDLE)
done       output  1        1-cycle completion pulse
err        output  1        1-cycle pulse coincident with done on timeout

Behaviour:
- All outputs registered. Reset (reset=0, async): state=IDLE, DMem_req=0, DMem_addr=0, Dmem_din=0, DMem_rd=1, memout=0, busy=0, done=0, err=0, wait counter=0. Reset mid-operation aborts immediately; no done is produced.
- States: IDLE, PTR (pointer read), GAP, ACC (data access), DONE.
- IDLE: start=1 latches op, addr_in, data_in. op[0]=1 -> PTR, else -> ACC. start is ignored in all other states.
- PTR: DMem_req=1, DMem_rd=1, DMem_addr=latched addr. On an edge with DMem_ack=1: latch pointer=DMem_dout[ADDR_W-1:0] and go to GAP.
- GAP: 1 cycle, DMem_req=0, then ACC using the pointer as the address.
- ACC: DMem_req=1. DMem_rd=~op[1]. Dmem_din=data_in for stores; Dmem_din holds its previous value for loads. On an edge with DMem_ack=1: loads update memout<=DMem_dout on that edge; go to DONE.
- DONE: 1 cycle, done=1, DMem_req=0, then IDLE.
- DMem_addr, Dmem_din and DMem_rd are held stable for the whole time DMem_req=1.
- DMem_ack is ignored while DMem_req=0.
- Latency, 0-wait memory (ack in first req cycle), counted from the start edge: direct op has req in cycle 1 and done in cycle 2; indirect op has PTR in cycle 1, GAP in cycle 2, ACC in cycle 3, done in cycle 4. Each extra wait cycle adds 1.
- Timeout (MAX_WAIT>0):
  - Counter clears on entry to PTR/ACC and increments each req cycle without ack.
  - If MAX_WAIT req cycles elapse without ack: go to DONE with err=1.
  - On timeout, memout is unchanged and no write is considered completed.
  - If ack arrives on the same edge the limit is reached, ack wins (no err).
- In IDLE, DMem_rd returns to 1; DMem_addr and Dmem_din hold their last values.
- Back-to-back: start may be asserted in the cycle after done; it is accepted, since that cycle is IDLE.

Test Plan:
- Reset mid-PTR: start op=01, drop reset during the wait -> all outputs return to reset values asynchronously; no done pulse.
- Load direct: start op=00, addr_in=0x3000; memory acks in first cycle with 0xBEEF -> DMem_rd=1, DMem_addr=0x3000; memout=0xBEEF; done in cycle 2; err=0.
- Store indirect: op=11, addr_in=0x4000, data_in=0x1234.
  - Memory returns pointer 0x5000 after 2 wait cycles -> GAP cycle with req=0.
  - Then write req with DMem_addr=0x5000, Dmem_din=0x1234, DMem_rd=0.
  - done in cycle 6.
- Timeout: MAX_WAIT=4, op=00, ack never asserted -> req held 4 cycles; done=1 and err=1 in the same cycle; memout unchanged. Repeat with ack on the 4th cycle -> err=0.
- Protocol robustness:
  - Pulse start while busy -> ignored.
  - Assert DMem_ack during GAP/IDLE -> ignored.
  - Issue back-to-back ops with start in the cycle after done -> both complete in order.
